l2_arbiter_fsm: RTL and testbench

//  Stateful arbiter sharing one L2 cache port between the L1 I-cache and L1 D-cache.

---
 rtl/l2_arbiter_fsm_if.sv | 87 ++++++++
 rtl/l2_arbiter_fsm.sv | 168 ++++++++++++++++
 tb/tb_l2_arbiter_fsm.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_fsm_if.sv
// ---------------------------------------------------------------------------
// l2_arbiter_fsm_if
//
// Purpose:
//   Bundles the L1 request side and the L2 command/response side of the
//   shared L2 port arbiter into one interface.
//
// Signal summary:
//   L1_i_read / L1_i_write   I-cache line read / write request (level)
//   L1_i_addr / L1_i_wdata   I-cache request address / write line
//   L1_d_read / L1_d_write   D-cache line read / writeback request (level)
//   L1_d_addr / L1_d_wdata   D-cache request address / write line
//   L2_resp / L2_rdata       L2 completion pulse / read line valid with it
//   L1_i_resp / L1_d_resp    completion returned to the owning L1 only
//   data_to_L1               read line returned to the L1s
//   L2_read / L2_write       command to L2
//   L2_addr / data_to_L2     address / write line to L2
//
// Modports:
//   slave  - the arbiter's view (takes requests, drives L2 commands)
//   master - the environment's view (L1 caches plus the L2 model)
// ---------------------------------------------------------------------------
interface l2_arbiter_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);

    logic              L1_i_read;
    logic              L1_i_write;
    logic [ADDR_W-1:0] L1_i_addr;
    logic [LINE_W-1:0] L1_i_wdata;
    logic              L1_d_read;
    logic              L1_d_write;
    logic [ADDR_W-1:0] L1_d_addr;
    logic [LINE_W-1:0] L1_d_wdata;
    logic              L2_resp;
    logic [LINE_W-1:0] L2_rdata;

    logic              L1_i_resp;
    logic              L1_d_resp;
    logic [LINE_W-1:0] data_to_L1;
    logic              L2_read;
    logic              L2_write;
    logic [ADDR_W-1:0] L2_addr;
    logic [LINE_W-1:0] data_to_L2;

    modport slave (
        input  L1_i_read,
        input  L1_i_write,
        input  L1_i_addr,
        input  L1_i_wdata,
        input  L1_d_read,
        input  L1_d_write,
        input  L1_d_addr,
        input  L1_d_wdata,
        input  L2_resp,
        input  L2_rdata,
        output L1_i_resp,
        output L1_d_resp,
        output data_to_L1,
        output L2_read,
        output L2_write,
        output L2_addr,
        output data_to_L2
    );

    modport master (
        output L1_i_read,
        output L1_i_write,
        output L1_i_addr,
        output L1_i_wdata,
        output L1_d_read,
        output L1_d_write,
        output L1_d_addr,
        output L1_d_wdata,
        output L2_resp,
        output L2_rdata,
        input  L1_i_resp,
        input  L1_d_resp,
        input  data_to_L1,
        input  L2_read,
        input  L2_write,
        input  L2_addr,
        input  data_to_L2
    );

endinterface

// File: rtl/l2_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// l2_arbiter_fsm
//
// Purpose:
//   Shares a single L2 cache port between the L1 I-cache and L1 D-cache.
//   One L1 is granted per transaction and keeps the grant until L2 answers
//   with L2_resp. The granted L1's address, command and write line are
//   routed to L2; the L2 read line and completion go back to that L1 only.
//   Round-robin between the two L1s on simultaneous requests, and a
//   watchdog flags an L2 that takes too long to respond.
//
// Parameters:
//   ADDR_W   address width on both sides
//   LINE_W   cache line width
//   TIMEOUT  cycles a granted transaction may wait before timeout_err sets
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        synchronous active-low reset
//   bus          l2_arbiter_fsm_if.slave (L1 requests, L2 command/response)
//   timeout_err  sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module l2_arbiter_fsm #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l2_arbiter_fsm_if.slave       bus,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        I_WR = 3'd2,
        D_RD = 3'd3,
        D_WR = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_grant_d;
    logic              grant_d;
    logic              take_grant;
    logic              port_i_req;
    logic              port_d_req;
    logic [CNT_W-1:0]  wait_cnt;

    assign port_i_req = bus.L1_i_read | bus.L1_i_write;
    assign port_d_req = bus.L1_d_read | bus.L1_d_write;

    // State register and round-robin history. last_grant_d resets to D so
    // that the I-cache wins the very first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
        end else begin
            state <= next_state;
            if (take_grant) begin
                last_grant_d <= grant_d;
            end
        end
    end

    // Next-state and output decode. In IDLE the arbiter picks a port (the
    // one not granted last time on a tie) and, within that port, a write
    // ahead of a read so a dirty writeback lands before the fill. Once
    // granted, the L2 side is steered straight from the owner's live inputs
    // and the other port is ignored until the transaction returns to IDLE.
    always_comb begin
        next_state     = state;
        take_grant     = 1'b0;
        grant_d        = 1'b0;
        bus.L2_read    = 1'b0;
        bus.L2_write   = 1'b0;
        bus.L2_addr    = '0;
        bus.data_to_L2 = '0;
        bus.data_to_L1 = '0;
        bus.L1_i_resp  = 1'b0;
        bus.L1_d_resp  = 1'b0;

        case (state)
            IDLE: begin
                if (port_i_req || port_d_req) begin
                    take_grant = 1'b1;
                    if (port_i_req && port_d_req) begin
                        grant_d = ~last_grant_d;
                    end else begin
                        grant_d = port_d_req;
                    end
                    if (grant_d) begin
                        next_state = bus.L1_d_write ? D_WR : D_RD;
                    end else begin
                        next_state = bus.L1_i_write ? I_WR : I_RD;
                    end
                end
            end

            I_RD: begin
                bus.L2_read    = 1'b1;
                bus.L2_addr    = bus.L1_i_addr;
                bus.data_to_L2 = bus.L1_i_wdata;
                bus.data_to_L1 = bus.L2_rdata;
                bus.L1_i_resp  = bus.L2_resp;
                if (bus.L2_resp) begin
                    next_state = IDLE;
                end
            end

            I_WR: begin
                bus.L2_write   = 1'b1;
                bus.L2_addr    = bus.L1_i_addr;
                bus.data_to_L2 = bus.L1_i_wdata;
                bus.L1_i_resp  = bus.L2_resp;
                if (bus.L2_resp) begin
                    next_state = IDLE;
                end
            end

            D_RD: begin
                bus.L2_read    = 1'b1;
                bus.L2_addr    = bus.L1_d_addr;
                bus.data_to_L2 = bus.L1_d_wdata;
                bus.data_to_L1 = bus.L2_rdata;
                bus.L1_d_resp  = bus.L2_resp;
                if (bus.L2_resp) begin
                    next_state = IDLE;
                end
            end

            D_WR: begin
                bus.L2_write   = 1'b1;
                bus.L2_addr    = bus.L1_d_addr;
                bus.data_to_L2 = bus.L1_d_wdata;
                bus.L1_d_resp  = bus.L2_resp;
                if (bus.L2_resp) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Watchdog. wait_cnt holds the number of cycles already spent waiting
    // in the current transaction; it saturates at TIMEOUT so the sticky
    // flag is raised once and the counter never wraps while L2 stays silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE || bus.L2_resp) begin
            wait_cnt <= '0;
        end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_l2_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// tb_l2_arbiter_fsm
//
// Directed bench for the shared L2 port arbiter. A transaction-level model
// (who owns the port, which command, how long it has waited) predicts the
// outputs every cycle; directed sequences add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_l2_arbiter_fsm;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int TIMEOUT = 8;

    localparam logic [LINE_W-1:0] BG_RDATA = {8{32'h0BADF00D}};
    localparam logic [LINE_W-1:0] LINE_A   = {8{32'h12345678}};
    localparam logic [LINE_W-1:0] LINE_AA  = {8{32'hAAAAAAAA}};
    localparam logic [LINE_W-1:0] LINE_55  = {8{32'h55555555}};
    localparam logic [LINE_W-1:0] LINE_I   = {8{32'h11110000}};
    localparam logic [LINE_W-1:0] LINE_D   = {8{32'hDDDD0000}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic timeout_err;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    l2_arbiter_fsm_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_arbiter_fsm #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .timeout_err(timeout_err)
    );

    // Single comparison point shared by the model and the directed checks.
    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic i_rd, input logic i_wr,
                                 input logic [ADDR_W-1:0] i_addr, input logic [LINE_W-1:0] i_wdata,
                                 input logic d_rd, input logic d_wr,
                                 input logic [ADDR_W-1:0] d_addr, input logic [LINE_W-1:0] d_wdata);
        bus.L1_i_read  = i_rd;
        bus.L1_i_write = i_wr;
        bus.L1_i_addr  = i_addr;
        bus.L1_i_wdata = i_wdata;
        bus.L1_d_read  = d_rd;
        bus.L1_d_write = d_wr;
        bus.L1_d_addr  = d_addr;
        bus.L1_d_wdata = d_wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: ownership, command and wait length per transaction.
    bit m_busy, m_owner_d, m_write, m_last_d, m_err, model_on;
    bit m_ireq, m_dreq;
    int m_waited;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_last_d = 1'b1;
            m_waited = 0;
            m_err    = 1'b0;
            model_on = 1'b1;
        end else if (!m_busy) begin
            m_ireq = bus.L1_i_read | bus.L1_i_write;
            m_dreq = bus.L1_d_read | bus.L1_d_write;
            if (m_ireq || m_dreq) begin
                m_owner_d = (m_ireq && m_dreq) ? !m_last_d : m_dreq;
                m_write   = m_owner_d ? bus.L1_d_write : bus.L1_i_write;
                m_last_d  = m_owner_d;
                m_busy    = 1'b1;
                m_waited  = 0;
            end
        end else if (bus.L2_resp) begin
            m_busy = 1'b0;
        end else begin
            m_waited++;
            if (m_waited > TIMEOUT) m_err = 1'b1;
        end
    end

    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_l2d, e_l1d;

    // Per-cycle compare against the model, mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            e_addr = !m_busy ? '0 : (m_owner_d ? bus.L1_d_addr : bus.L1_i_addr);
            e_l2d  = !m_busy ? '0 : (m_owner_d ? bus.L1_d_wdata : bus.L1_i_wdata);
            e_l1d  = (m_busy && !m_write) ? bus.L2_rdata : '0;
            checkOutput("model L2_read", bus.L2_read, m_busy && !m_write);
            checkOutput("model L2_write", bus.L2_write, m_busy && m_write);
            checkOutput("model L2_addr", bus.L2_addr, e_addr);
            checkOutput("model data_to_L2", bus.data_to_L2, e_l2d);
            checkOutput("model data_to_L1", bus.data_to_L1, e_l1d);
            checkOutput("model L1_i_resp", bus.L1_i_resp, m_busy && !m_owner_d && bus.L2_resp);
            checkOutput("model L1_d_resp", bus.L1_d_resp, m_busy && m_owner_d && bus.L2_resp);
            // The one cycle where "exceeds TIMEOUT" can be read either way is skipped.
            if (!(m_busy && !m_err && m_waited == TIMEOUT)) begin
                checkOutput("model timeout_err", timeout_err, m_err);
            end
        end
    end

    // Called in an IDLE cycle with the requests already set: grant, one
    // wait cycle, response, then the mandatory IDLE cycle.
    task automatic serve(input string name, input bit port_d, input bit is_write,
                         input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                         input logic [LINE_W-1:0] rdata);
        next_cycle();
        #1;
        checkOutput({name, " addr"}, bus.L2_addr, addr);
        checkOutput({name, " cmd"}, {bus.L2_write, bus.L2_read}, is_write ? 2'b10 : 2'b01);
        if (is_write) checkOutput({name, " wdata"}, bus.data_to_L2, wdata);
        next_cycle();
        bus.L2_rdata = rdata;
        bus.L2_resp  = 1'b1;
        #1;
        checkOutput({name, " resp"}, {bus.L1_i_resp, bus.L1_d_resp}, port_d ? 2'b01 : 2'b10);
        if (!is_write) checkOutput({name, " rdata"}, bus.data_to_L1, rdata);
        next_cycle();
        bus.L2_resp  = 1'b0;
        bus.L2_rdata = BG_RDATA;
        #1;
        checkOutput({name, " idle"}, {bus.L2_read, bus.L2_write}, 2'b00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
        bus.L2_resp  = 1'b0;
        bus.L2_rdata = BG_RDATA;

        // Reset state
        do_reset();
        #1;
        checkOutput("reset timeout_err", timeout_err, 1'b0);
        checkOutput("reset cmd", {bus.L2_read, bus.L2_write}, 2'b00);
        checkOutput("reset addr", bus.L2_addr, '0);
        checkOutput("reset data_to_L1", bus.data_to_L1, '0);

        // I read @0x100, L2 answers 3 cycles after L2_read rises
        applyStimulus(1, 0, 32'h100, '0, 0, 0, '0, '0);
        #1;
        checkOutput("t1 pre-grant read", bus.L2_read, 1'b0);
        next_cycle();
        checkOutput("t1 L2_read", bus.L2_read, 1'b1);
        checkOutput("t1 L2_addr", bus.L2_addr, 32'h100);
        next_cycle();
        next_cycle();
        next_cycle();
        bus.L2_rdata = LINE_A;
        bus.L2_resp  = 1'b1;
        #1;
        checkOutput("t1 i_resp", bus.L1_i_resp, 1'b1);
        checkOutput("t1 d_resp", bus.L1_d_resp, 1'b0);
        checkOutput("t1 data_to_L1", bus.data_to_L1, LINE_A);
        next_cycle();
        bus.L2_resp     = 1'b0;
        bus.L2_rdata    = BG_RDATA;
        bus.L1_i_read   = 1'b0;
        #1;
        checkOutput("t1 idle", bus.L2_read, 1'b0);

        // Simultaneous I and D reads after reset: I first, then D
        do_reset();
        applyStimulus(1, 0, 32'h300, '0, 1, 0, 32'h400, '0);
        serve("t2 first I", 0, 0, 32'h300, '0, LINE_I);
        bus.L1_i_read = 1'b0;
        serve("t2 then D", 1, 0, 32'h400, '0, LINE_D);
        // Both held continuously: strict I,D,I,D alternation
        bus.L1_i_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve((k % 2) ? "t2 alt D" : "t2 alt I", k[0], 0,
                  (k % 2) ? 32'h400 : 32'h300, '0, (k % 2) ? LINE_D : LINE_I);
        end
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);

        // D read + D write together: writeback first, then the fill
        applyStimulus(0, 0, '0, '0, 1, 1, 32'h200, LINE_AA);
        serve("t3 D write", 1, 1, 32'h200, LINE_AA, LINE_A);
        bus.L1_d_write = 1'b0;
        serve("t3 D read", 1, 0, 32'h200, LINE_AA, LINE_A);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);

        // D write arrives during an I read: I keeps the port until resp
        applyStimulus(1, 0, 32'h500, LINE_I, 0, 0, '0, '0);
        next_cycle();
        applyStimulus(1, 0, 32'h500, LINE_I, 0, 1, 32'h600, LINE_55);
        #1;
        checkOutput("t4 addr held", bus.L2_addr, 32'h500);
        checkOutput("t4 no write", bus.L2_write, 1'b0);
        next_cycle();
        checkOutput("t4 addr still I", bus.L2_addr, 32'h500);
        bus.L2_resp = 1'b1;
        #1;
        checkOutput("t4 resp to I", {bus.L1_i_resp, bus.L1_d_resp}, 2'b10);
        next_cycle();
        bus.L2_resp   = 1'b0;
        bus.L1_i_read = 1'b0;
        #1;
        checkOutput("t4 idle", {bus.L2_read, bus.L2_write}, 2'b00);
        serve("t4 D write", 1, 1, 32'h600, LINE_55, LINE_A);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);

        // L2_resp pulse while IDLE is ignored
        bus.L2_resp = 1'b1;
        #1;
        checkOutput("t6 resp in idle", {bus.L1_i_resp, bus.L1_d_resp}, 2'b00);
        next_cycle();
        bus.L2_resp = 1'b0;
        #1;
        checkOutput("t6 still idle", {bus.L2_read, bus.L2_write}, 2'b00);

        // L2 never answers: watchdog sets and sticks, reset clears it
        applyStimulus(1, 0, 32'h700, '0, 0, 0, '0, '0);
        next_cycle();
        repeat (3) next_cycle();
        checkOutput("t5 early no timeout", timeout_err, 1'b0);
        repeat (12) next_cycle();
        checkOutput("t5 timeout set", timeout_err, 1'b1);
        checkOutput("t5 still waiting", bus.L2_read, 1'b1);
        next_cycle();
        checkOutput("t5 timeout sticky", timeout_err, 1'b1);
        rst_n = 1'b0;
        bus.L1_i_read = 1'b0;
        next_cycle();
        checkOutput("t5 reset clears err", timeout_err, 1'b0);
        checkOutput("t5 reset idle", bus.L2_read, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        checkOutput("t5 after reset", {timeout_err, bus.L2_read}, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
